// File: rtl/l1_trigger_pkg.sv
// Shared definitions for the L1 trigger threshold/rate-control Wishbone target.
package l1_trigger_pkg;

    localparam logic [1:0] ADR_CTRL   = 2'b00;
    localparam logic [1:0] ADR_COUNT  = 2'b01;
    localparam logic [1:0] ADR_THRESH = 2'b10;

    localparam int unsigned STAT_DONE_BIT = 0;
    localparam int unsigned STAT_BUSY_BIT = 1;

    localparam int unsigned THRESH_BITS = 18;
    localparam int unsigned COUNT_BITS  = 32;

    typedef enum logic {
        ST_IDLE,
        ST_COUNTING
    } win_state_t;

    // Byte-lane merge of a write into an 18-bit threshold (lane 2 carries bits 17:16).
    function automatic logic [THRESH_BITS-1:0] merge_thresh(
        input logic [THRESH_BITS-1:0] old_value,
        input logic [31:0]            data,
        input logic [3:0]             lanes
    );
        logic [THRESH_BITS-1:0] result;
        result = old_value;
        if (lanes[0]) result[7:0]   = data[7:0];
        if (lanes[1]) result[15:8]  = data[15:8];
        if (lanes[2]) result[17:16] = data[17:16];
        return result;
    endfunction

endpackage

// File: rtl/l1_beam_rate_counter.sv
// Per-beam trigger accumulator with saturation, latched into a count register at window end.
module l1_beam_rate_counter
    import l1_trigger_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  count_en,
    input  logic                  window_end,
    input  logic                  trig,
    output logic [COUNT_BITS-1:0] count
);

    logic [COUNT_BITS-1:0] acc;
    logic [COUNT_BITS-1:0] acc_sum;

    // Saturating add of this cycle's trigger.
    always_comb begin
        acc_sum = (acc == '1) ? acc : acc + COUNT_BITS'(trig);
    end

    // Accumulate while counting; on the final cycle publish the total and clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
        end else if (count_en) begin
            if (window_end) begin
                count <= acc_sum;
                acc   <= '0;
            end else begin
                acc <= acc_sum;
            end
        end
    end

endmodule

// File: rtl/l1_threshold_wb_target.sv
// Wishbone target for L1 trigger thresholds and per-beam trigger rate counting windows.
module l1_threshold_wb_target
    import l1_trigger_pkg::*;
#(
    parameter int unsigned            NBEAMS          = 2,
    parameter int unsigned            COUNT_CLOCKS    = 375000000,
    parameter logic [THRESH_BITS-1:0] STARTING_THRESH = 18'h3FFFF
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          wb_cyc_i,
    input  logic                          wb_stb_i,
    input  logic                          wb_we_i,
    input  logic [21:0]                   wb_adr_i,
    input  logic [31:0]                   wb_dat_i,
    input  logic [3:0]                    wb_sel_i,
    output logic                          wb_ack_o,
    output logic                          wb_err_o,
    output logic                          wb_rty_o,
    output logic [31:0]                   wb_dat_o,
    input  logic [NBEAMS-1:0]             trig_i,
    output logic [NBEAMS*THRESH_BITS-1:0] thresholds_o,
    output logic                          thresh_update_o
);

    localparam int unsigned WIN_BITS = $clog2(COUNT_CLOCKS + 1);

    win_state_t             state;
    logic [WIN_BITS-1:0]    win_cnt;
    logic                   done;
    logic                   busy;
    logic                   window_end;
    logic                   access;
    logic                   start_req;
    logic [1:0]             adr_sel;
    logic [7:0]             adr_beam;
    logic [31:0]            rd_data;
    logic [THRESH_BITS-1:0] thr      [NBEAMS];
    logic [THRESH_BITS-1:0] thr_next [NBEAMS];
    logic                   thr_changed;
    logic [COUNT_BITS-1:0]  count    [NBEAMS];
    logic                   unused_bits;

    assign wb_err_o    = 1'b0;
    assign wb_rty_o    = 1'b0;
    assign unused_bits = ^wb_adr_i[21:10];

    assign access     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign adr_sel    = wb_adr_i[9:8];
    assign adr_beam   = wb_adr_i[7:0];
    assign start_req  = access & wb_we_i & (adr_sel == ADR_CTRL) & wb_dat_i[0] & wb_sel_i[0];
    assign busy       = (state == ST_COUNTING);
    assign window_end = busy && (win_cnt == WIN_BITS'(COUNT_CLOCKS - 1));

    // Read mux; unmatched beam indices and the reserved select fall through to zero.
    always_comb begin
        rd_data = '0;
        case (adr_sel)
            ADR_CTRL: begin
                rd_data[STAT_DONE_BIT] = done;
                rd_data[STAT_BUSY_BIT] = busy;
            end
            ADR_COUNT: begin
                for (int unsigned i = 0; i < NBEAMS; i++)
                    if (adr_beam == 8'(i)) rd_data = 32'(count[i]);
            end
            ADR_THRESH: begin
                for (int unsigned i = 0; i < NBEAMS; i++)
                    if (adr_beam == 8'(i)) rd_data = 32'(thr[i]);
            end
            default: ;
        endcase
    end

    // Next threshold bank value and whether the accepted write actually alters it.
    always_comb begin
        thr_next    = thr;
        thr_changed = 1'b0;
        if (access && wb_we_i && (adr_sel == ADR_THRESH)) begin
            for (int unsigned i = 0; i < NBEAMS; i++) begin
                if (adr_beam == 8'(i)) begin
                    thr_next[i] = merge_thresh(thr[i], wb_dat_i, wb_sel_i);
                    thr_changed = (thr_next[i] != thr[i]);
                end
            end
        end
    end

    // Flatten the threshold bank onto the trigger-facing bus.
    always_comb begin
        thresholds_o = '0;
        for (int unsigned i = 0; i < NBEAMS; i++)
            thresholds_o[THRESH_BITS*i +: THRESH_BITS] = thr[i];
    end

    // Single-cycle ack with read data captured on the accepting edge.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= access;
            if (access) wb_dat_o <= wb_we_i ? '0 : rd_data;
        end
    end

    // Threshold bank and the change pulse that accompanies a new value.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int unsigned i = 0; i < NBEAMS; i++) thr[i] <= STARTING_THRESH;
            thresh_update_o <= 1'b0;
        end else begin
            thr             <= thr_next;
            thresh_update_o <= thr_changed;
        end
    end

    // Count-window FSM; starts are only honoured from IDLE.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= ST_IDLE;
            win_cnt <= '0;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state   <= ST_COUNTING;
                        win_cnt <= '0;
                        done    <= 1'b0;
                    end
                end
                ST_COUNTING: begin
                    if (window_end) begin
                        state   <= ST_IDLE;
                        win_cnt <= '0;
                        done    <= 1'b1;
                    end else begin
                        win_cnt <= win_cnt + WIN_BITS'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NBEAMS; g++) begin : g_beam
        l1_beam_rate_counter u_counter (
            .clk        (wb_clk_i),
            .rst        (wb_rst_i),
            .count_en   (busy),
            .window_end (window_end),
            .trig       (trig_i[g]),
            .count      (count[g])
        );
    end

endmodule

// File: tb/tb_l1_threshold_wb_target.sv
// Randomized self-checking bench for l1_threshold_wb_target against a window-sum reference model.
module tb_l1_threshold_wb_target;

    localparam int NB = 2;
    localparam int CC = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [21:0] adr = '0;
    logic [31:0] wdat = '0;
    logic [3:0]  sel = '0;
    logic        ack;
    logic        err;
    logic        rty;
    logic [31:0] rdat;
    logic [1:0]  trig = '0;
    logic [35:0] thr_bus;
    logic        upd;

    int checks = 0;
    int errors = 0;

    l1_threshold_wb_target #(
        .NBEAMS          (NB),
        .COUNT_CLOCKS    (CC),
        .STARTING_THRESH (18'h3FFFF)
    ) dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .wb_cyc_i        (cyc),
        .wb_stb_i        (stb),
        .wb_we_i         (we),
        .wb_adr_i        (adr),
        .wb_dat_i        (wdat),
        .wb_sel_i        (sel),
        .wb_ack_o        (ack),
        .wb_err_o        (err),
        .wb_rty_o        (rty),
        .wb_dat_o        (rdat),
        .trig_i          (trig),
        .thresholds_o    (thr_bus),
        .thresh_update_o (upd)
    );

    always #5 clk = ~clk;

    // Per-edge trigger log; edge number k holds the trig_i value sampled at that edge.
    logic [1:0] trig_log [0:8191];
    int         cyc_no = 0;
    always @(posedge clk) begin
        trig_log[cyc_no] <= trig;
        cyc_no           <= cyc_no + 1;
    end

    int upd_seen = 0;
    always @(negedge clk) if (upd) upd_seen <= upd_seen + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference model state
    int          start_edge = -1;
    logic [31:0] old_count [NB];
    logic [17:0] thr_model [NB];
    int          upd_exp = 0;
    bit          rand_trig = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] win_sum(int b, int s);
        longint t = 0;
        for (int k = s + 1; k <= s + CC; k++) t += longint'(trig_log[k][b]);
        if (t > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
        return t[31:0];
    endfunction

    // State seen by an access accepted at edge x is the state left by edge x-1.
    function automatic bit model_busy(int x);
        return start_edge >= 0 && (x - 1) >= start_edge && (x - 1) < start_edge + CC;
    endfunction

    function automatic bit model_done(int x);
        return start_edge >= 0 && (x - 1) >= start_edge + CC;
    endfunction

    function automatic logic [31:0] model_read(logic [21:0] a, int x);
        int b;
        b = int'(a[7:0]);
        case (a[9:8])
            2'b00: return {30'b0, model_busy(x), model_done(x)};
            2'b01: if (b < NB) return model_done(x) ? win_sum(b, start_edge) : old_count[b];
            2'b10: if (b < NB) return {14'b0, thr_model[b]};
            default: ;
        endcase
        return 32'h0;
    endfunction

    task automatic model_write(input logic [21:0] a, input logic [31:0] d, input logic [3:0] s, input int x);
        int          b;
        logic [17:0] mask;
        logic [17:0] nv;
        b = int'(a[7:0]);
        if (a[9:8] == 2'b00 && d[0] && s[0] && !model_busy(x)) begin
            if (model_done(x))
                for (int i = 0; i < NB; i++) old_count[i] = win_sum(i, start_edge);
            start_edge = x;
        end else if (a[9:8] == 2'b10 && b < NB) begin
            mask = {s[2] ? 2'b11 : 2'b00, s[1] ? 8'hFF : 8'h00, s[0] ? 8'hFF : 8'h00};
            nv   = (thr_model[b] & ~mask) | (d[17:0] & mask);
            if (nv != thr_model[b]) upd_exp++;
            thr_model[b] = nv;
        end
    endtask

    task automatic model_reset();
        start_edge = -1;
        for (int i = 0; i < NB; i++) begin
            old_count[i] = '0;
            thr_model[i] = 18'h3FFFF;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_trig) trig = 2'($urandom);
        end
    endtask

    task automatic xfer(input bit w, input logic [21:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output int acc_edge);
        int n;
        if (ack) begin
            @(posedge clk);
            #1;
            check("ack_one_cycle", 64'(ack), 64'h0);
        end
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        n = 0;
        while (n < 4) begin
            @(posedge clk);
            #1;
            n++;
            if (ack) break;
        end
        check("ack_latency", 64'(n), 64'd1);
        rd       = rdat;
        acc_edge = cyc_no - 1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [21:0] a, output logic [31:0] rd);
        int e;
        xfer(1'b0, a, 32'h0, 4'hF, rd, e);
        check(tag, 64'(rd), 64'(model_read(a, e)));
    endtask

    task automatic wr(input logic [21:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        int          e;
        xfer(1'b1, a, d, s, rd, e);
        model_write(a, d, s, e);
    endtask

    task automatic poll_done();
        logic [31:0] rd;
        bit          seen;
        seen = 0;
        for (int t = 0; t < 40; t++) begin
            rd_check("status_poll", 22'h000, rd);
            if (rd[0]) begin
                seen = 1;
                break;
            end
        end
        check("done_within_bound", 64'(seen), 64'h1);
    endtask

    initial begin
        logic [31:0] rd;
        int          s;
        model_reset();

        // Reset state
        tick(3);
        check("rst_ack", 64'(ack), 64'h0);
        check("rst_dat", 64'(rdat), 64'h0);
        check("rst_thr_bus", 64'(thr_bus), {28'h0, 18'h3FFFF, 18'h3FFFF});
        check("rst_upd", 64'(upd), 64'h0);
        rst = 1'b0;
        tick(1);
        rd_check("rd_thr0_rst", 22'h200, rd);
        check("thr0_rst_abs", 64'(rd), 64'h3FFFF);
        rd_check("rd_thr1_rst", 22'h201, rd);
        rd_check("rd_status_rst", 22'h000, rd);
        check("err_rty_zero", {62'h0, err, rty}, 64'h0);
        check("no_upd_after_rst", 64'(upd_seen), 64'h0);

        // Basic window: beam0 every cycle, beam1 for three cycles
        trig = 2'b01;
        wr(22'h000, 32'h1, 4'hF);
        trig = 2'b11;
        tick(3);
        trig = 2'b01;
        rd_check("status_busy", 22'h000, rd);
        check("status_busy_abs", 64'(rd), 64'h2);
        poll_done();
        rd_check("count0", 22'h100, rd);
        check("count0_abs", 64'(rd), 64'd16);
        rd_check("count1", 22'h101, rd);
        check("count1_abs", 64'(rd), 64'd3);

        // Threshold writes
        wr(22'h200, 32'h12345, 4'b0111);
        check("thr_new", 64'(thr_bus[17:0]), 64'h12345);
        check("upd_pulse", 64'(upd), 64'h1);
        tick(2);
        wr(22'h200, 32'h12345, 4'b0111);
        check("no_upd_same", 64'(upd), 64'h0);
        wr(22'h200, 32'h000000AA, 4'b0001);
        check("thr_lane0", 64'(thr_bus[17:0]), 64'h123AA);
        tick(2);
        check("upd_count_a", 64'(upd_seen), 64'(upd_exp));
        check("thr_bus_model", 64'(thr_bus), {28'h0, thr_model[1], thr_model[0]});

        // Second start mid-window ignored; restart after done keeps old counts until window end
        rand_trig = 1;
        wr(22'h000, 32'h1, 4'hF);
        tick(5);
        wr(22'h000, 32'h1, 4'hF);
        rd_check("status_mid", 22'h000, rd);
        poll_done();
        rd_check("count0_w2", 22'h100, rd);
        rd_check("count1_w2", 22'h101, rd);
        wr(22'h000, 32'h1, 4'hF);
        rd_check("status_restart", 22'h000, rd);
        rd_check("count0_old", 22'h100, rd);
        rd_check("count1_old", 22'h101, rd);
        poll_done();
        rd_check("count0_w3", 22'h100, rd);
        rd_check("count1_w3", 22'h101, rd);

        // Randomized operations
        for (int k = 0; k < 60; k++) begin
            int          op;
            logic [21:0] a;
            op = $urandom_range(0, 4);
            a  = {12'h0, 2'($urandom), 8'($urandom_range(0, 3))};
            case (op)
                0: rd_check("rand_read", a, rd);
                1: begin
                    wr({12'h0, 2'b10, a[7:0]}, $urandom, 4'($urandom));
                    check("rand_thr_bus", 64'(thr_bus), {28'h0, thr_model[1], thr_model[0]});
                end
                2: wr(22'h000, 32'($urandom_range(0, 1)), 4'($urandom));
                3: wr({12'h0, 2'b01, a[7:0]}, $urandom, 4'hF);
                default: tick($urandom_range(1, 6));
            endcase
        end
        if (start_edge >= 0) poll_done();
        rd_check("rand_count0", 22'h100, rd);
        rd_check("rand_count1", 22'h101, rd);

        // Unmapped and read-only addresses
        rd_check("rd_102", 22'h102, rd);
        rd_check("rd_300", 22'h300, rd);
        rd_check("rd_3ff", 22'h3FF, rd);
        wr(22'h100, 32'hFFFF_FFFF, 4'hF);
        rd_check("count_ro", 22'h100, rd);
        wr(22'h300, 32'h0, 4'hF);
        wr(22'h202, 32'h0, 4'hF);
        check("thr_unmapped_wr", 64'(thr_bus), {28'h0, thr_model[1], thr_model[0]});
        check("upd_count_b", 64'(upd_seen), 64'(upd_exp));

        // Back-to-back accesses are acked every other cycle
        begin
            logic [3:0] pat;
            if (ack) tick(1);
            cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 22'h200;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk);
                #1;
                pat[i] = ack;
            end
            cyc = 1'b0; stb = 1'b0;
            check("b2b_ack_pattern", 64'(pat), 64'b0101);
        end

        // Reset mid-window
        rand_trig = 0;
        trig = 2'b11;
        wr(22'h201, 32'h0, 4'hF);
        wr(22'h000, 32'h1, 4'hF);
        tick(5);
        rst = 1'b1;
        #1;
        check("midrst_thr_bus", 64'(thr_bus), {28'h0, 18'h3FFFF, 18'h3FFFF});
        check("midrst_ack", 64'(ack), 64'h0);
        check("midrst_dat", 64'(rdat), 64'h0);
        model_reset();
        tick(2);
        rst = 1'b0;
        tick(1);
        rd_check("midrst_status", 22'h000, rd);
        rd_check("midrst_count0", 22'h100, rd);
        rd_check("midrst_count1", 22'h101, rd);
        check("upd_count_c", 64'(upd_seen), 64'(upd_exp));

        // Saturation of a preloaded accumulator
        wr(22'h000, 32'h1, 4'hF);
        tick(3);
        force dut.g_beam[0].u_counter.acc = 32'hFFFF_FFFE;
        tick(1);
        release dut.g_beam[0].u_counter.acc;
        poll_done();
        begin
            int e;
            xfer(1'b0, 22'h100, 32'h0, 4'hF, rd, e);
            check("count0_saturated", 64'(rd), 64'hFFFF_FFFF);
        end
        rd_check("count1_sat_win", 22'h101, rd);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
